// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the multiply-accumulate sequencer.
//   - mac_state_e : sequencer states (IDLE, ISSUE, WAIT, ACCUM, OUT)
//   - MAC_ACC_W   : default accumulator / result width
//   - MAC_MUL_LAT : default multiplier latency in cycles
package mac_pkg;

    localparam int MAC_ACC_W   = 24;
    localparam int MAC_MUL_LAT = 9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACCUM = 3'd3,
        ST_OUT   = 3'd4
    } mac_state_e;

endpackage

// File: rtl/mac_lat_cnt.sv
// mac_lat_cnt: wait counter that times out the multiplier latency.
// Ports:
//   clk   in  clock
//   rst_n in  asynchronous active-low reset
//   clr   in  force count to zero (has priority over en)
//   en    in  increment count
//   tc    out count currently equals MUL_LAT-1
module mac_lat_cnt
    import mac_pkg::*;
#(
    parameter int MUL_LAT = MAC_MUL_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int              CW     = $clog2(MUL_LAT) + 1;
    localparam logic [CW-1:0]   TC_VAL = CW'(MUL_LAT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/mac_seq.sv
// mac_seq: multiply-accumulate sequencer feeding an external sequential
// multiplier. Accepts one operand pair at a time, pulses mul_start, waits
// MUL_LAT cycles, adds the product into the accumulator and, on the pair
// flagged last, presents the sum with a sticky overflow flag.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in_a, in_b operands, in_last closes sum
//   mul_start             one-cycle start pulse to the multiplier
//   mul_a, mul_b          operands held for the multiplier
//   mul_op                product returned by the multiplier
//   acc_valid/acc_ready   result handshake
//   acc_out, acc_ovf      accumulated sum and sticky carry-out flag
module mac_seq
    import mac_pkg::*;
#(
    parameter int ACC_W   = MAC_ACC_W,
    parameter int MUL_LAT = MAC_MUL_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             mul_start,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [15:0]      mul_op,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_ovf
);

    mac_state_e       state_q;
    logic [7:0]       mul_a_q;
    logic [7:0]       mul_b_q;
    logic             last_q;
    logic             in_ready_q;
    logic             mul_start_q;
    logic             acc_valid_q;
    logic [ACC_W-1:0] acc_q;
    logic             acc_ovf_q;

    logic             lat_tc;
    // One extra bit so the carry out of the accumulator is visible.
    logic [ACC_W:0]   acc_sum_d;

    assign acc_sum_d = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, mul_op};

    mac_lat_cnt #(
        .MUL_LAT (MUL_LAT)
    ) u_lat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == ST_ISSUE),
        .en    (state_q == ST_WAIT),
        .tc    (lat_tc)
    );

    // Control and handshake outputs are registered: each transition sets
    // the output values that belong to the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            mul_start_q <= 1'b0;
            acc_valid_q <= 1'b0;
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        mul_a_q     <= in_a;
                        mul_b_q     <= in_b;
                        last_q      <= in_last;
                        in_ready_q  <= 1'b0;
                        mul_start_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mul_start_q <= 1'b0;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (lat_tc) begin
                        state_q <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    acc_q <= acc_sum_d[ACC_W-1:0];
                    if (acc_sum_d[ACC_W]) begin
                        acc_ovf_q <= 1'b1;
                    end
                    if (last_q) begin
                        acc_valid_q <= 1'b1;
                        state_q     <= ST_OUT;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_OUT: begin
                    if (acc_ready) begin
                        acc_q       <= '0;
                        acc_ovf_q   <= 1'b0;
                        acc_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    mul_start_q <= 1'b0;
                    acc_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign acc_valid = acc_valid_q;
    assign acc_out   = acc_q;
    assign acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_mac_seq.sv
module tb_mac_seq;

    localparam int L = 9;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid = 1'b0;
    logic [7:0] in_a = 8'd0;
    logic [7:0] in_b = 8'd0;
    logic       in_last = 1'b0;
    logic       acc_ready = 1'b0;

    // 24-bit instance
    logic        rdy24, st24, av24, ov24;
    logic [7:0]  ma24, mb24;
    logic [15:0] op24;
    logic [23:0] out24;
    // 16-bit instance driven by the same stimulus
    logic        rdy16, st16, av16, ov16;
    logic [7:0]  ma16, mb16;
    logic [15:0] op16;
    logic [15:0] out16;

    mac_seq #(.ACC_W(24), .MUL_LAT(L)) dut24 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy24),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_start(st24),
        .mul_a(ma24), .mul_b(mb24), .mul_op(op24), .acc_valid(av24),
        .acc_ready(acc_ready), .acc_out(out24), .acc_ovf(ov24)
    );

    mac_seq #(.ACC_W(16), .MUL_LAT(L)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy16),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_start(st16),
        .mul_a(ma16), .mul_b(mb16), .mul_op(op16), .acc_valid(av16),
        .acc_ready(acc_ready), .acc_out(out16), .acc_ovf(ov16)
    );

    // Behavioural multipliers: product appears exactly L cycles after the
    // edge that samples mul_start; otherwise the bus carries noise.
    logic        pv24 [0:L];
    logic [15:0] pp24 [0:L];
    logic        pv16 [0:L];
    logic [15:0] pp16 [0:L];
    logic [15:0] junk = 16'h5a5a;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= L; i++) pv24[i] <= 1'b0;
        end else begin
            pv24[0] <= st24;
            pp24[0] <= 16'(ma24) * 16'(mb24);
            for (int i = 1; i <= L; i++) begin
                pv24[i] <= pv24[i-1];
                pp24[i] <= pp24[i-1];
            end
            junk <= 16'($urandom);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j <= L; j++) pv16[j] <= 1'b0;
        end else begin
            pv16[0] <= st16;
            pp16[0] <= 16'(ma16) * 16'(mb16);
            for (int j = 1; j <= L; j++) begin
                pv16[j] <= pv16[j-1];
                pp16[j] <= pp16[j-1];
            end
        end
    end

    assign op24 = pv24[L] ? pp24[L] : junk;
    assign op16 = pv16[L] ? pp16[L] : junk;

    // Reference model: timeline relative to the acceptance cycle, plus the
    // exact integer sum of all terms of the open sum.
    int         cyc = 0;
    int         t_acc = 0;
    int         k = 0;
    bit         busy = 1'b0;
    bit         outv = 1'b0;
    logic [7:0] ea = 8'd0;
    logic [7:0] eb = 8'd0;
    bit         el = 1'b0;
    longint     sum = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy = 1'b0; outv = 1'b0; k = 0; sum = 0;
            ea = 8'd0; eb = 8'd0; el = 1'b0;
        end else begin
            if (outv) begin
                if (acc_ready) begin
                    outv = 1'b0;
                    sum  = 0;
                end
            end else if (busy) begin
                if (k == L + 2) begin
                    sum  = sum + longint'(ea) * longint'(eb);
                    busy = 1'b0;
                    outv = el;
                end else begin
                    k = k + 1;
                end
            end else if (in_valid) begin
                ea = in_a; eb = in_b; el = in_last;
                busy = 1'b1; k = 1; t_acc = cyc;
            end
            cyc = cyc + 1;
        end
    end

    int errs = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    logic [31:0] e_acc24, e_acc16;
    logic        e_ov24, e_ov16;
    logic        prev_av = 1'b0;
    int          lat = 0;
    int          nstart = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            e_acc24 = 32'(sum & 64'hFF_FFFF);
            e_acc16 = 32'(sum & 64'hFFFF);
            e_ov24  = (sum >= (longint'(1) << 24));
            e_ov16  = (sum >= (longint'(1) << 16));
            check("in_ready24",  32'(rdy24), 32'(!busy && !outv));
            check("in_ready16",  32'(rdy16), 32'(!busy && !outv));
            check("mul_start24", 32'(st24),  32'(busy && k == 1));
            check("mul_start16", 32'(st16),  32'(busy && k == 1));
            check("mul_a",       32'(ma24),  32'(ea));
            check("mul_b",       32'(mb24),  32'(eb));
            check("acc_valid24", 32'(av24),  32'(outv));
            check("acc_valid16", 32'(av16),  32'(outv));
            check("acc_out24",   32'(out24), e_acc24);
            check("acc_out16",   32'(out16), e_acc16);
            check("acc_ovf24",   32'(ov24),  32'(e_ov24));
            check("acc_ovf16",   32'(ov16),  32'(e_ov16));
            if (av24 && !prev_av) lat = cyc - t_acc;
            if (st24) nstart++;
        end
        prev_av = av24;
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        n = 0;
        while (rdy24 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("send_accept_timeout", 32'(rdy24), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (av24 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("acc_valid_timeout", 32'(av24), 32'd1);
    endtask

    task automatic get_sum(input int hold, output logic [23:0] r24, output logic o24,
                           output logic [15:0] r16, output logic o16);
        acc_ready = 1'b0;
        wait_valid();
        r24 = out24; o24 = ov24; r16 = out16; o16 = ov16;
        repeat (hold) @(negedge clk);
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
    endtask

    logic [23:0] r24;
    logic [15:0] r16;
    logic        o24, o16;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(rdy24), 32'd1);
        check("rst_mul_start", 32'(st24),  32'd0);
        check("rst_acc_valid", 32'(av24),  32'd0);
        check("rst_acc_out",   32'(out24), 32'd0);
        check("rst_mul_a",     32'(ma24),  32'd0);
        rst_n = 1'b1;

        // (3,5) single-term sum
        nstart = 0;
        send(8'd3, 8'd5, 1'b1);
        get_sum(0, r24, o24, r16, o16);
        check("t1_acc_out",   32'(r24),  32'd15);
        check("t1_acc_ovf",   32'(o24),  32'd0);
        check("t1_acc_out16", 32'(r16),  32'd15);
        check("t1_latency",   32'(lat),  32'd12);
        check("t1_starts",    32'(nstart), 32'd1);

        // three (255,255)
        send(8'd255, 8'd255, 1'b0);
        send(8'd255, 8'd255, 1'b0);
        send(8'd255, 8'd255, 1'b1);
        get_sum(0, r24, o24, r16, o16);
        check("t2_acc_out",   32'(r24), 32'd195075);
        check("t2_acc_ovf",   32'(o24), 32'd0);
        check("t2_acc_out16", 32'(r16), 32'd64003);
        check("t2_acc_ovf16", 32'(o16), 32'd1);

        // two (255,255): 16-bit wraps
        send(8'd255, 8'd255, 1'b0);
        send(8'd255, 8'd255, 1'b1);
        get_sum(0, r24, o24, r16, o16);
        check("t3_acc_out16", 32'(r16), 32'd64514);
        check("t3_acc_ovf16", 32'(o16), 32'd1);
        check("t3_acc_out",   32'(r24), 32'd130050);

        // (1,1) with acc_ready held low 5 cycles and in_valid pulses
        send(8'd1, 8'd1, 1'b1);
        acc_ready = 1'b0;
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0]; in_a = 8'(i + 40); in_b = 8'd7; in_last = 1'b1;
            check("hold_in_ready", 32'(rdy24), 32'd0);
            check("hold_acc_out",  32'(out24), 32'd1);
            check("hold_acc_ovf",  32'(ov24),  32'd0);
            check("hold_ovf16",    32'(ov16),  32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;

        // reset in the middle of WAIT
        send(8'd7, 8'd9, 1'b0);
        send(8'd8, 8'd8, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  32'(rdy24), 32'd1);
        check("mid_rst_mul_start", 32'(st24),  32'd0);
        check("mid_rst_mul_a",     32'(ma24),  32'd0);
        check("mid_rst_mul_b",     32'(mb16),  32'd0);
        check("mid_rst_acc_out",   32'(out24), 32'd0);
        check("mid_rst_acc_valid", 32'(av16),  32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        send(8'd0, 8'd200, 1'b1);
        get_sum(0, r24, o24, r16, o16);
        check("t5_acc_out", 32'(r24), 32'd0);
        check("t5_acc_ovf", 32'(o24), 32'd0);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
            in_b      = ($urandom_range(0, 3) == 0) ? 8'd255 : 8'($urandom);
            in_last   = ($urandom_range(0, 3) == 0);
            acc_ready = ($urandom_range(0, 2) == 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        acc_ready = 1'b1;
        repeat (30) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
